// File: rtl/nn_pkg.sv
// Shared constants for the neuron datapath: fp32 literals, activation codes, FSM encoding.
package nn_pkg;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    localparam int unsigned ACT_LINEAR = 0;
    localparam int unsigned ACT_RELU   = 1;

    localparam logic [1:0] ST_ACC  = 2'd0;
    localparam logic [1:0] ST_BIAS = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/float_adder.sv
// Combinational fp32 adder: align, add/subtract, renormalise, round-to-nearest-even.
module float_adder
    import nn_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [31:0]        x, z;
    logic [7:0]         d;
    logic [26:0]        mx, mz, sh, m;
    logic [27:0]        sum;
    logic [24:0]        mr;
    logic [4:0]         lz;
    logic               found;
    logic signed [9:0]  e;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic               unused_hidden;

    // Larger magnitude goes to x so the difference is never negative; sticky bit kept through the shift.
    always_comb begin
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        if (a[30:0] >= b[30:0]) begin
            x = a;
            z = b;
        end else begin
            x = b;
            z = a;
        end
        mx = {1'b1, x[22:0], 3'b000};
        mz = {1'b1, z[22:0], 3'b000};
        d  = x[30:23] - z[30:23];
        if (d >= 8'd27) begin
            sh = 27'd1;
        end else begin
            sh = mz >> d;
            if ((mz & ~(27'h7FF_FFFF << d)) != 27'd0) sh[0] = 1'b1;
        end
        if (x[31] == z[31]) sum = {1'b0, mx} + {1'b0, sh};
        else                sum = {1'b0, mx} - {1'b0, sh};
        e     = 10'(x[30:23]);
        lz    = 5'd0;
        found = 1'b0;
        if (sum[27]) begin
            m = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'sd1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (!found && sum[i]) begin
                    lz    = 5'(26 - i);
                    found = 1'b1;
                end
            end
            m = sum[26:0] << lz;
            e = e - 10'(lz);
        end
        mr = {1'b0, m[26:3]} + 25'(m[2] & ((|m[1:0]) | m[3]));
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'sd1;
        end
        y = {x[31], e[7:0], mr[22:0]};
        if (sum == 28'd0)      y = FP_ZERO;
        else if (e >= 10'sd255) y = {x[31], 8'hFF, 23'd0};
        else if (e <= 10'sd0)   y = {x[31], 31'd0};
        if (a_nan || b_nan)      y = FP_QNAN;
        else if (a_inf && b_inf) y = (a[31] == b[31]) ? a : FP_QNAN;
        else if (a_inf)          y = a;
        else if (b_inf)          y = b;
        else if (a_zero && b_zero) y = {a[31] & b[31], 31'd0};
        else if (a_zero)         y = b;
        else if (b_zero)         y = a;
    end

    assign unused_hidden = mr[23];

endmodule

// File: rtl/float_mult.sv
// Combinational fp32 multiplier: round-to-nearest-even, denormals flushed to signed zero.
module float_mult
    import nn_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic               sgn;
    logic [47:0]        prod;
    logic [23:0]        mant;
    logic [24:0]        mr;
    logic               g;
    logic               st;
    logic signed [9:0]  e;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic               unused_hidden;

    // Multiply significands, normalise by one bit at most, round, then override special cases.
    always_comb begin
        sgn    = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e      = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (prod[47]) begin
            mant = prod[47:24];
            g    = prod[23];
            st   = |prod[22:0];
            e    = e + 10'sd1;
        end else begin
            mant = prod[46:23];
            g    = prod[22];
            st   = |prod[21:0];
        end
        mr = {1'b0, mant} + 25'(g & (st | mant[0]));
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'sd1;
        end
        y = {sgn, e[7:0], mr[22:0]};
        if (e >= 10'sd255)    y = {sgn, 8'hFF, 23'd0};
        else if (e <= 10'sd0) y = {sgn, 31'd0};
        if (a_nan || b_nan)                          y = FP_QNAN;
        else if ((a_inf && b_zero) || (b_inf && a_zero)) y = FP_QNAN;
        else if (a_inf || b_inf)                     y = {sgn, 8'hFF, 23'd0};
        else if (a_zero || b_zero)                   y = {sgn, 31'd0};
    end

    assign unused_hidden = mr[23];

endmodule

// File: rtl/nn_weight_rf.sv
// Weight/bias register file: N_IN weights plus bias at address N_IN, sync write, async read.
module nn_weight_rf #(
    parameter  int unsigned N_IN = 15,
    localparam int unsigned AW   = $clog2(N_IN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata,
    output logic [31:0]   bias
);

    logic [31:0] rf_q [N_IN+1];
    logic [31:0] rf_d [N_IN+1];

    // Next-state of the file: out-of-range addresses leave it untouched.
    always_comb begin
        rf_d = rf_q;
        if (we && (waddr <= AW'(N_IN))) rf_d[waddr] = wdata;
    end

    // Storage, cleared to +0.0 on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= int'(N_IN); i++) rf_q[i] <= 32'h0000_0000;
        end else begin
            rf_q <= rf_d;
        end
    end

    assign rdata = rf_q[ridx];
    assign bias  = rf_q[N_IN];

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed fp32 neuron: streamed dot product with loaded weights, bias add, activation.
module neuron_mac_seq
    import nn_pkg::*;
#(
    parameter  int unsigned N_IN = 15,
    parameter  int unsigned ACT  = ACT_RELU,
    localparam int unsigned AW   = $clog2(N_IN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_we,
    input  logic [AW-1:0] w_addr,
    input  logic [31:0]   w_data,
    output logic          w_ack,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_err
);

    localparam logic [AW-1:0] IDX_LAST = AW'(N_IN - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   acc_q, acc_d;
    logic          len_err_q, len_err_d;
    logic          w_ack_q, w_ack_d;
    logic          rf_we;
    logic [31:0]   w_rd, b_rd, prod, add_b, sum;

    nn_weight_rf #(.N_IN(N_IN)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (w_addr),
        .wdata (w_data),
        .ridx  (idx_q),
        .rdata (w_rd),
        .bias  (b_rd)
    );

    float_mult  u_mult (.a(in_data), .b(w_rd),  .y(prod));
    float_adder u_add  (.a(acc_q),   .b(add_b), .y(sum));

    // Single adder is shared: products while accumulating, bias in the BIAS cycle.
    assign add_b = (state_q == ST_BIAS) ? b_rd : prod;

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        len_err_d = len_err_q;
        w_ack_d   = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            ST_ACC: begin
                if (w_we && (idx_q == '0) && (w_addr <= AW'(N_IN))) begin
                    rf_we   = 1'b1;
                    w_ack_d = 1'b1;
                end
                if (in_valid) begin
                    acc_d = sum;
                    idx_d = idx_q + AW'(1);
                    if (in_last || (idx_q == IDX_LAST)) begin
                        state_d   = ST_BIAS;
                        len_err_d = (in_last && (idx_q != IDX_LAST)) ||
                                    ((idx_q == IDX_LAST) && !in_last);
                    end
                end
            end
            ST_BIAS: begin
                acc_d   = sum;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d     = FP_ZERO;
                    idx_d     = '0;
                    len_err_d = 1'b0;
                    state_d   = ST_ACC;
                end
            end
            default: begin
                state_d   = ST_ACC;
                idx_d     = '0;
                acc_d     = FP_ZERO;
                len_err_d = 1'b0;
            end
        endcase
    end

    // State and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACC;
            idx_q     <= '0;
            acc_q     <= FP_ZERO;
            len_err_q <= 1'b0;
            w_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            len_err_q <= len_err_d;
            w_ack_q   <= w_ack_d;
        end
    end

    assign w_ack     = w_ack_q;
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign out_err   = out_valid & len_err_q;
    assign out_data  = !out_valid                           ? FP_ZERO :
                       ((ACT == ACT_RELU) && acc_q[31])     ? FP_ZERO : acc_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq with N_IN=3, ReLU and linear instances in lockstep.
module tb_neuron_mac_seq;

    localparam int unsigned N_IN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_we;
    logic [1:0]  w_addr;
    logic [31:0] w_data;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        r_w_ack, r_in_ready, r_out_valid, r_out_err;
    logic [31:0] r_out_data;
    logic        l_w_ack, l_in_ready, l_out_valid, l_out_err;
    logic [31:0] l_out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neuron_mac_seq #(.N_IN(N_IN), .ACT(1)) u_relu (
        .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_ack(r_w_ack),
        .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data), .out_err(r_out_err)
    );

    neuron_mac_seq #(.N_IN(N_IN), .ACT(0)) u_lin (
        .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_ack(l_w_ack),
        .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data), .out_err(l_out_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                        input logic iv, input logic [31:0] id, input logic il);
        w_we = we; w_addr = addr; w_data = wd;
        in_valid = iv; in_data = id; in_last = il;
        tick();
        w_we = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send(input string tag, input logic [31:0] d, input logic last);
        check_eq({tag, "_rdy"}, 32'(r_in_ready), 32'd1);
        step(1'b0, 2'd0, 32'd0, 1'b1, d, last);
    endtask

    task automatic wr(input string tag, input logic [1:0] addr, input logic [31:0] d, input logic exp_ack);
        step(1'b1, addr, d, 1'b0, 32'd0, 1'b0);
        check_eq({tag, "_ack"}, 32'(r_w_ack), 32'(exp_ack));
    endtask

    task automatic load_weights(input string tag);
        wr({tag, "_w0"}, 2'd0, 32'h3F80_0000, 1'b1);
        wr({tag, "_w1"}, 2'd1, 32'h4000_0000, 1'b1);
        wr({tag, "_w2"}, 2'd2, 32'hBF80_0000, 1'b1);
        wr({tag, "_b"},  2'd3, 32'h3F00_0000, 1'b1);
    endtask

    task automatic pop(input string tag, input logic [31:0] exp_r, input logic [31:0] exp_l, input logic exp_err);
        int n = 0;
        while (!r_out_valid && n < 8) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid"}, 32'(r_out_valid), 32'd1);
        check_eq({tag, "_relu"},  r_out_data, exp_r);
        check_eq({tag, "_lin"},   l_out_data, exp_l);
        check_eq({tag, "_err"},   32'(r_out_err), 32'(exp_err));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_drop"}, 32'(r_out_valid), 32'd0);
    endtask

    task automatic vec111(input string tag);
        send(tag, 32'h3F80_0000, 1'b0);
        send(tag, 32'h3F80_0000, 1'b0);
        send(tag, 32'h3F80_0000, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; w_we = 1'b0; w_addr = 2'd0; w_data = 32'd0;
        in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        check_eq("rst_valid", 32'(r_out_valid), 32'd0);
        check_eq("rst_data",  r_out_data, 32'd0);
        check_eq("rst_err",   32'(r_out_err), 32'd0);
        check_eq("rst_ack",   32'(r_w_ack), 32'd0);
        check_eq("rst_rdy",   32'(r_in_ready), 32'd1);

        load_weights("ld");
        tick();
        check_eq("ack_pulse", 32'(r_w_ack), 32'd0);

        // Basic vector with latency check: 1*1 + 1*2 + 1*(-1) + 0.5 = 2.5
        vec111("t1");
        check_eq("t1_bias_valid", 32'(r_out_valid), 32'd0);
        check_eq("t1_bias_rdy",   32'(r_in_ready), 32'd0);
        tick();
        check_eq("t1_lat", 32'(r_out_valid), 32'd1);
        pop("t1", 32'h4020_0000, 32'h4020_0000, 1'b0);

        // Negative result: ReLU clamps, linear gives -3.5
        send("t2", 32'h0000_0000, 1'b0);
        send("t2", 32'h0000_0000, 1'b0);
        send("t2", 32'h4080_0000, 1'b1);
        pop("t2", 32'h0000_0000, 32'hC060_0000, 1'b0);

        // Backpressure: output holds while a stray element is offered
        vec111("t3");
        tick();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h4080_0000;
            check_eq("t3_hold_valid", 32'(r_out_valid), 32'd1);
            check_eq("t3_hold_data",  r_out_data, 32'h4020_0000);
            check_eq("t3_hold_rdy",   32'(r_in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        pop("t3", 32'h4020_0000, 32'h4020_0000, 1'b0);
        vec111("t3b");
        pop("t3b", 32'h4020_0000, 32'h4020_0000, 1'b0);

        // Short vector: 1 + 2 + 0.5 = 3.5 with error; missing last: 2.5 with error
        send("t4a", 32'h3F80_0000, 1'b0);
        send("t4a", 32'h3F80_0000, 1'b1);
        pop("t4a", 32'h4060_0000, 32'h4060_0000, 1'b1);
        send("t4b", 32'h3F80_0000, 1'b0);
        send("t4b", 32'h3F80_0000, 1'b0);
        send("t4b", 32'h3F80_0000, 1'b0);
        pop("t4b", 32'h4020_0000, 32'h4020_0000, 1'b1);

        // Mid-vector write is dropped
        send("t5a", 32'h3F80_0000, 1'b0);
        wr("t5a_mid", 2'd0, 32'h4080_0000, 1'b0);
        send("t5a", 32'h3F80_0000, 1'b0);
        send("t5a", 32'h3F80_0000, 1'b1);
        pop("t5a", 32'h4020_0000, 32'h4020_0000, 1'b0);
        // Idle write W0=2.0 accepted: 2 + 2 - 1 + 0.5 = 3.5
        wr("t5b_idle", 2'd0, 32'h4000_0000, 1'b1);
        vec111("t5b");
        pop("t5b", 32'h4060_0000, 32'h4060_0000, 1'b0);
        // Write W0=3.0 together with first element: element still sees 2.0 -> 3.5
        step(1'b1, 2'd0, 32'h4040_0000, 1'b1, 32'h3F80_0000, 1'b0);
        check_eq("t5c_ack", 32'(r_w_ack), 32'd1);
        send("t5c", 32'h3F80_0000, 1'b0);
        send("t5c", 32'h3F80_0000, 1'b1);
        pop("t5c", 32'h4060_0000, 32'h4060_0000, 1'b0);
        // Next vector uses 3.0: 3 + 2 - 1 + 0.5 = 4.5
        vec111("t5d");
        pop("t5d", 32'h4090_0000, 32'h4090_0000, 1'b0);

        // Reset mid-vector clears partial sum and weights
        send("t6", 32'h3F80_0000, 1'b0);
        send("t6", 32'h3F80_0000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_valid", 32'(r_out_valid), 32'd0);
        check_eq("t6_rdy",   32'(r_in_ready), 32'd1);
        vec111("t6z");
        pop("t6z", 32'h0000_0000, 32'h0000_0000, 1'b0);
        load_weights("t6ld");
        vec111("t6r");
        pop("t6r", 32'h4020_0000, 32'h4020_0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
